// File: rtl/ysyx_25010008_fetch_unit.sv
// ysyx_25010008_fetch_unit: multi-cycle AXI4-Lite instruction fetch stage, one instruction in flight
module ysyx_25010008_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  fetch_err,
    output logic        inst_valid,
    input  logic        inst_ready
);
    typedef enum logic [1:0] {S_AR, S_R, S_OUT, S_NPC} state_t;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_BUS   = 2'd2;
    localparam logic [1:0] ERR_TIME  = 2'd3;
    localparam logic       TO_EN     = TIMEOUT != 0;
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [7:0]  cnt;
    logic        misaligned;
    logic        timed_out;

    assign misaligned = pc[1:0] != 2'b00;
    assign timed_out  = TO_EN && cnt == TO_LAST && !rvalid;
    assign araddr     = pc;
    assign arvalid    = rst && state == S_AR && !misaligned;
    assign rready     = rst && state == S_R;
    assign inst_valid = rst && state == S_OUT;

    // Fetch sequencing: address phase, data wait with timeout, hold for decode, wait for next PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_AR;
            pc        <= RESET_PC;
            cnt       <= 8'd0;
            inst      <= 32'd0;
            inst_pc   <= 32'd0;
            fetch_err <= ERR_OK;
        end else begin
            case (state)
                S_AR: begin
                    if (misaligned) begin
                        state     <= S_OUT;
                        inst      <= 32'd0;
                        inst_pc   <= pc;
                        fetch_err <= ERR_ALIGN;
                    end else if (arready) begin
                        state <= S_R;
                        cnt   <= 8'd0;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        state     <= S_OUT;
                        inst      <= rdata;
                        inst_pc   <= pc;
                        fetch_err <= rresp != 2'b00 ? ERR_BUS : ERR_OK;
                    end else if (timed_out) begin
                        state     <= S_OUT;
                        inst      <= 32'd0;
                        inst_pc   <= pc;
                        fetch_err <= ERR_TIME;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_OUT: begin
                    if (inst_ready) state <= S_NPC;
                end
                S_NPC: begin
                    if (npc_valid) begin
                        pc    <= npc;
                        state <= S_AR;
                    end
                end
                default: state <= S_AR;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25010008_fetch_unit.sv
// tb_ysyx_25010008_fetch_unit: randomized scoreboard bench with a transaction-level fetch model
module tb_ysyx_25010008_fetch_unit;
    localparam int          TIMEOUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  fetch_err;
    logic        inst_valid;
    logic        inst_ready;

    ysyx_25010008_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .npc_valid(npc_valid), .npc(npc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          ar_wait;
        int          r_wait;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;
    int   planned_ar = 0;
    int   ar_hs = 0;
    int   rdy_mode = 1;
    bus_t cur;
    int   ph = 0;
    int   k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%h required=no pending transaction", name, act);
    endtask

    // Reference model: what decode must see for a fetch at address a, given the memory's behaviour
    task automatic plan(input logic [31:0] a, input int aw, input int rw, input logic [1:0] rs, input logic [31:0] d);
        exp_t e;
        bus_t b;
        e.pc = a;
        if (a[1:0] != 2'b00) begin
            e.inst = 32'd0;
            e.err  = 2'd1;
        end else begin
            b.addr = a; b.data = d; b.resp = rs; b.ar_wait = aw; b.r_wait = rw;
            bus_q.push_back(b);
            planned_ar++;
            e.inst = rw >= TIMEOUT ? 32'd0 : d;
            e.err  = rw >= TIMEOUT ? 2'd3 : (rs != 2'b00 ? 2'd2 : 2'd0);
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] a, input int aw, input int rw, input logic [1:0] rs);
        plan(a, aw, rw, rs, $urandom);
        npc = a;
        npc_valid = 1'b1;
        @(posedge clk); #1;
        npc_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            npc = $urandom;
            npc_valid = exp_q.size() != 0 && $urandom_range(0, 3) == 0;
            n++;
        end
        npc_valid = 1'b0;
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: every cycle decode sees a valid instruction it must match the head entry
    always @(negedge clk) begin
        if (rst && inst_valid) begin
            if (exp_q.size() == 0) fail("inst_unexpected", inst_pc);
            else begin
                chk("inst", inst, exp_q[0].inst);
                chk("inst_pc", inst_pc, exp_q[0].pc);
                chk("fetch_err", {30'd0, fetch_err}, {30'd0, exp_q[0].err});
                if (inst_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Decode-side ready: always, never, or random
    initial begin
        inst_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            inst_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : $urandom_range(0, 3) != 0;
        end
    end

    // Memory slave: serves planned transactions with their AR and R delays
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        forever begin
            @(posedge clk); #1;
            arready = 1'b0; rvalid = 1'b0; rresp = 2'd0; rdata = $urandom;
            if (!rst) ph = 0;
            else begin
                if (ph == 0 && arvalid) begin
                    if (bus_q.size() == 0) fail("ar_unexpected", araddr);
                    else begin
                        cur = bus_q.pop_front();
                        ph = 1;
                    end
                end
                if (ph == 1) begin
                    chk("ar_valid_held", {31'd0, arvalid}, 1);
                    chk("araddr", araddr, cur.addr);
                    if (cur.ar_wait == 0) begin
                        arready = 1'b1;
                        ar_hs++;
                        ph = 2;
                        k = 0;
                    end else cur.ar_wait--;
                end else if (ph == 2) begin
                    chk("rready", {31'd0, rready}, {31'd0, k < TIMEOUT});
                    if (k == cur.r_wait) begin
                        rvalid = 1'b1;
                        rdata = cur.data;
                        rresp = cur.resp;
                        ph = 0;
                    end
                    k++;
                end
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        rst = 1'b0; npc = 32'd0; npc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid0", {31'd0, arvalid}, 0);
        chk("rst_inst0", inst, 0);
        plan(RESET_PC, 0, 0, 2'd0, 32'h0000_0413);
        @(negedge clk); rst = 1'b1; #1;
        chk("first_arvalid", {31'd0, arvalid}, 1);
        chk("first_araddr", araddr, RESET_PC);
        @(posedge clk); #2; chk("first_ar_hs", {31'd0, arvalid && arready}, 1);
        @(posedge clk); #2; chk("first_r_hs", {31'd0, rready && rvalid}, 1);
        @(posedge clk); #2; chk("first_inst_valid", {31'd0, inst_valid}, 1);
        wait_done();

        send(32'h8000_0100, 0, 0, 2'd0);
        #1; chk("lat_arvalid", {31'd0, arvalid}, 1);
        @(posedge clk); #2; chk("lat_not_yet", {31'd0, inst_valid}, 0);
        @(posedge clk); #2; chk("lat_inst_valid", {31'd0, inst_valid}, 1);
        wait_done();

        send(RESET_PC, 5, 1, 2'd0);
        wait_done();

        rdy_mode = 2;
        send(32'h8000_0008, 0, 2, 2'd0);
        n = 0;
        while (!inst_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("hold_reached", {31'd0, inst_valid}, 1);
        repeat (4) begin
            npc = 32'h8000_0010; npc_valid = 1'b1;
            @(posedge clk); #1;
        end
        npc_valid = 1'b0;
        rdy_mode = 1;
        wait_done();
        send(32'h8000_0004, 0, 0, 2'd0); wait_done();

        send(32'h8000_0006, 0, 0, 2'd0); wait_done();
        send(32'h8000_0001, 0, 0, 2'd0); wait_done();
        send(32'h8000_0020, 0, 1, 2'b10); wait_done();
        send(32'h8000_0024, 0, 4, 2'd0); wait_done();
        send(32'h8000_0028, 2, 5, 2'd0); wait_done();
        send(32'h8000_002C, 0, 3, 2'd0); wait_done();
        send(32'hFFFF_FFFC, 1, 0, 2'd0); wait_done();

        rdy_mode = 0;
        repeat (60) begin
            a = $urandom_range(0, 15) == 0 ? 32'hFFFF_FFFC : RESET_PC + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            send(a, $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0 ? $urandom_range(4, 5) : $urandom_range(0, 3),
                 $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 3)) : 2'd0);
            wait_done();
        end

        rdy_mode = 1;
        send(32'h8000_0040, 0, 3, 2'd0);
        n = 0;
        while (!rready && n < 50) begin @(posedge clk); #1; n++; end
        chk("pre_rst_rready", {31'd0, rready}, 1);
        @(negedge clk); #2; rst = 1'b0; #1;
        chk("rst_rready", {31'd0, rready}, 0);
        chk("rst_arvalid", {31'd0, arvalid}, 0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 0);
        exp_q.delete();
        bus_q.delete();
        plan(RESET_PC, 0, 1, 2'd0, $urandom);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1; #1;
        chk("restart_araddr", araddr, RESET_PC);
        wait_done();

        chk("ar_handshakes", ar_hs, planned_ar);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
